// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in/parallel-out receiver.
package sipo_pkg;

  localparam int unsigned SIPO_DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_e;

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit counter for sipo_rx: counts sampled bits and flags the bit that completes a word.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0] r_count;
  logic          w_terminal;

  assign w_terminal = (r_count == CW'(WIDTH - 1));
  assign o_done     = i_inc & ~i_clr & w_terminal;

  // Wraps straight to zero on the completing bit, so the count never reaches WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_terminal ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver, MSB first, with a single-entry holding register and overrun flag.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             busy
);

  sipo_state_e      r_state;
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-1:0] r_parallel;
  logic             r_out_valid;
  logic             r_overrun;

  logic             w_sample;
  logic             w_done;
  logic             w_drop;
  logic [WIDTH-1:0] w_word;

  assign w_sample = serial_valid & ~flush;
  assign w_word   = {r_shift, serial_in};
  assign w_drop   = w_done & r_out_valid & ~out_ready;

  sipo_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_sample),
    .i_clr (flush),
    .o_done(w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_parallel  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (flush) begin
        r_state <= IDLE;
        r_shift <= '0;
      end else if (serial_valid) begin
        if (w_done) begin
          r_state <= IDLE;
          r_shift <= '0;
        end else begin
          r_state <= SHIFT;
          r_shift <= w_word[WIDTH-2:0];
        end
      end

      // A completing word may replace the held one only if it is being consumed on this edge.
      if (w_done) begin
        if (!r_out_valid || out_ready) begin
          r_parallel  <= w_word;
          r_out_valid <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      r_overrun <= w_drop | (r_overrun & ~clr_overrun);
    end
  end

  assign parallel_out = r_parallel;
  assign out_valid    = r_out_valid;
  assign overrun      = r_overrun;
  assign busy         = (r_state == SHIFT);

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: directed tables, corner sequences and a random run vs a bit-queue model.
module tb_sipo_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         serial_in = 1'b0;
  logic         serial_valid = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] parallel_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         overrun;
  logic         clr_overrun = 1'b0;
  logic         busy;

  int checks = 0;
  int failures = 0;

  // Reference model: list of bits received so far plus the holding register.
  bit           m_bits[$];
  logic [W-1:0] m_word;
  logic         m_valid;
  logic         m_ovr;

  typedef struct {
    logic         sv, b, fl, rdy, clr;
    logic [W-1:0] e_out;
    logic         e_valid, e_ovr, e_busy;
  } vec_t;

  vec_t tbl[9];

  sipo_rx #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_in   (serial_in),
    .serial_valid(serial_valid),
    .flush       (flush),
    .parallel_out(parallel_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_word  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_edge(input logic sv, b, fl, rdy, clr);
    bit           done = 0;
    bit           drop;
    logic [W-1:0] w = '0;
    if (fl) begin
      m_bits.delete();
    end else if (sv) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) if (m_bits[i]) w = w + (W'(1) << (W - 1 - i));
        m_bits.delete();
        done = 1;
      end
    end
    drop = done && m_valid && !rdy;
    if (done) begin
      if (!drop) begin
        m_word  = w;
        m_valid = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out"}, 32'(parallel_out), 32'(m_word));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".busy"}, 32'(busy), 32'(m_bits.size() != 0));
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic apply(input logic sv, b, fl, rdy, clr, input string tag);
    serial_valid = sv;
    serial_in    = b;
    flush        = fl;
    out_ready    = rdy;
    clr_overrun  = clr;
    @(posedge clk);
    model_edge(sv, b, fl, rdy, clr);
    #1;
    check_model(tag);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic rdy_last,
                           input string tag);
    for (int i = W - 1; i >= 0; i--) apply(1'b1, w[i], 1'b0, (i == 0) ? rdy_last : rdy, 1'b0, tag);
  endtask

  task automatic idle(input int n, input logic rdy, input string tag);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, rdy, 1'b0, tag);
  endtask

  initial begin
    logic [W-1:0] pat;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    #2 rst_n = 1'b1;

    // Basic word A5 as a table.
    pat = 8'hA5;
    for (int i = 0; i < W; i++) begin
      tbl[i].sv = 1'b1; tbl[i].b = pat[W-1-i]; tbl[i].fl = 1'b0; tbl[i].rdy = 1'b1;
      tbl[i].clr = 1'b0;
      tbl[i].e_out   = (i == W - 1) ? 8'hA5 : 8'h00;
      tbl[i].e_valid = (i == W - 1);
      tbl[i].e_ovr   = 1'b0;
      tbl[i].e_busy  = (i != W - 1);
    end
    tbl[8].sv = 1'b0; tbl[8].b = 1'b0; tbl[8].fl = 1'b0; tbl[8].rdy = 1'b1; tbl[8].clr = 1'b0;
    tbl[8].e_out = 8'hA5; tbl[8].e_valid = 1'b0; tbl[8].e_ovr = 1'b0; tbl[8].e_busy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].sv, tbl[i].b, tbl[i].fl, tbl[i].rdy, tbl[i].clr, "a5");
      chk("tbl.out", 32'(parallel_out), 32'(tbl[i].e_out));
      chk("tbl.valid", 32'(out_valid), 32'(tbl[i].e_valid));
      chk("tbl.ovr", 32'(overrun), 32'(tbl[i].e_ovr));
      chk("tbl.busy", 32'(busy), 32'(tbl[i].e_busy));
    end

    // Gaps after bits 2 and 5.
    pat = 8'h3C;
    for (int i = 0; i < W; i++) begin
      apply(1'b1, pat[W-1-i], 1'b0, 1'b1, 1'b0, "gap");
      if (i < W - 1) chk("gap.busy", 32'(busy), 32'd1);
      if (i == 1 || i == 4) idle(3, 1'b1, "gap");
    end
    chk("gap.word", 32'(parallel_out), 32'h3C);
    chk("gap.busy_end", 32'(busy), 32'd0);
    idle(1, 1'b1, "gap");

    // Backpressure and overrun, then clear.
    send_word(8'h11, 1'b0, 1'b0, "bp");
    send_word(8'h22, 1'b0, 1'b0, "bp");
    chk("bp.held", 32'(parallel_out), 32'h11);
    chk("bp.ovr", 32'(overrun), 32'd1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bp");
    chk("bp.clr", 32'(overrun), 32'd0);
    idle(1, 1'b1, "bp");

    // Same-edge consume and complete.
    send_word(8'h11, 1'b0, 1'b0, "same");
    send_word(8'h22, 1'b0, 1'b1, "same");
    chk("same.out", 32'(parallel_out), 32'h22);
    chk("same.valid", 32'(out_valid), 32'd1);
    chk("same.ovr", 32'(overrun), 32'd0);
    idle(1, 1'b1, "same");

    // Flush beats a simultaneous bit.
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "flush");
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "flush");
    chk("flush.busy", 32'(busy), 32'd0);
    send_word(8'hF0, 1'b1, 1'b1, "flush");
    chk("flush.word", 32'(parallel_out), 32'hF0);
    idle(1, 1'b1, "flush");

    // Asynchronous reset mid-word.
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "rst");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.out", 32'(parallel_out), 32'd0);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ovr", 32'(overrun), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    send_word(8'h81, 1'b1, 1'b1, "rst");
    chk("rst.word", 32'(parallel_out), 32'h81);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 19) == 0),
            1'($urandom), ($urandom_range(0, 9) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the deserialized word width in bits (legal 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port serial_in, input, 1, the serial data bit, MSB of each word first.
REQ-005 The block SHALL have port serial_valid, input, 1, which qualifies serial_in; a bit is sampled only on an edge where serial_valid=1.
REQ-006 The block SHALL have port flush, input, 1, a synchronous abort that discards any partial word.
REQ-007 The block SHALL have port parallel_out, output, WIDTH, the registered holding register with the last completed word.
REQ-008 The block SHALL have port out_valid, output, 1, high while parallel_out holds an unconsumed word.
REQ-009 The block SHALL have port out_ready, input, 1; a word is consumed on an edge where out_valid=1 and out_ready=1.
REQ-010 The block SHALL have port overrun, output, 1, a sticky flag set when a completed word is dropped.
REQ-011 The block SHALL have port clr_overrun, input, 1, a synchronous clear for overrun.
REQ-012 The block SHALL have port busy, output, 1, high while a partial word (1..WIDTH-1 bits) is held.

Function
REQ-013 The block SHALL implement FSM states IDLE (0 bits held) and SHIFT (1..WIDTH-1 bits held).
REQ-014 In IDLE, a sampled bit SHALL move the FSM to SHIFT with the bit count = 1.
REQ-015 In SHIFT, each sampled bit SHALL shift left into the shift register LSB and increment the bit count.
REQ-016 When a sampled bit makes the count reach WIDTH, the FSM SHALL return to IDLE, the count SHALL reset to 0, and the word is complete.
REQ-017 The bit count SHALL be $clog2(WIDTH+1) bits wide and SHALL never exceed WIDTH.
REQ-018 A completed word SHALL appear on parallel_out with out_valid=1 at the same edge that samples its last bit (zero added latency after that edge).
REQ-019 parallel_out SHALL be the first sampled bit at bit WIDTH-1 through the last sampled bit at bit 0.
REQ-020 parallel_out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 On a consume edge with no word completing, out_valid SHALL go to 0 and parallel_out SHALL hold its value.
REQ-022 On an edge where a word completes and out_valid=1 with out_ready=1, the block SHALL load the new word and keep out_valid=1, with no overrun.
REQ-023 On an edge where a word completes and out_valid=1 with out_ready=0, the block SHALL drop the new word, keep the old word, and set overrun=1.
REQ-024 Gaps with serial_valid=0 SHALL hold the FSM state, count and shift register unchanged, however long the gap.
REQ-025 flush=1 SHALL force IDLE, count=0 and busy=0 at the next edge.
REQ-026 When flush and serial_valid are both 1, flush SHALL win and the bit SHALL be discarded.
REQ-027 flush SHALL NOT affect parallel_out, out_valid or overrun.
REQ-028 When clr_overrun=1 and a new drop occur on the same edge, overrun SHALL end at 1 (set wins).
REQ-029 busy SHALL equal (state==SHIFT), decoded from registered state.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=IDLE, count=0, shift register=0, parallel_out=0, out_valid=0, overrun=0 and busy=0.
REQ-031 Reset asserted mid-word SHALL discard the partial word; the first sampled bit after release SHALL be the MSB of a new word.

Structure
REQ-032 A shared package sipo_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and the default WIDTH constant.
REQ-033 The bit counter with its increment, terminal-count and clear logic SHALL be one sub-module, sipo_bit_counter, parameterized by WIDTH; all other logic SHALL stay in sipo_rx.

Verification
REQ-034 Basic word: WIDTH=8, send bits 1,0,1,0,0,1,0,1 on consecutive cycles with out_ready=1 -> parallel_out=8'hA5 and out_valid=1 for one cycle at the 8th edge.
REQ-035 Gaps: send 8'h3C with serial_valid=0 for 3 cycles after bits 2 and 5 -> parallel_out=8'h3C, busy high from the 1st bit to the 7th bit.
REQ-036 Backpressure and overrun: with out_ready=0 send 8'h11 then 8'h22 -> parallel_out stays 8'h11 and overrun=1 after the 16th bit; clr_overrun -> overrun=0.
REQ-037 Same-edge consume: hold 8'h11 unconsumed, assert out_ready exactly on the edge where 8'h22 completes -> parallel_out=8'h22, out_valid=1, overrun=0.
REQ-038 Flush: send 3 bits, then flush together with serial_valid=1, then send 8'hF0 -> parallel_out=8'hF0 and no earlier word is output.
REQ-039 Reset mid-word: send 5 bits, pulse rst_n low asynchronously between edges -> all outputs 0 immediately; then send 8'h81 -> parallel_out=8'h81.
